mult_div_unit: RTL

// - Iterative HI/LO multiply/divide unit for the simplified MIPS core; sits directly downstream of the register file.
// - Operands come from register-file read ports 1/2 (rs/rt).
// - Results are held in HI/LO; MFHI/MFLO are served by an external write-back mux that reads MDU_hi/MDU_lo.
// - Radix-2 shift-add multiply and restoring divide, 33 cycles per operation; MDU_busy stalls issue.

---
 rtl/mdu_pkg.sv | 22 ++
 rtl/mdu_signfix.sv | 12 +
 rtl/mult_div_unit.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared op/state encodings and widths for the HI/LO multiply/divide unit
package mdu_pkg;

  localparam int MDU_DATA_W = 32;
  localparam int MDU_CNT_W  = 5;

  typedef enum logic [2:0] {
    MDU_OP_MULT  = 3'b000,
    MDU_OP_MULTU = 3'b001,
    MDU_OP_DIV   = 3'b010,
    MDU_OP_DIVU  = 3'b011,
    MDU_OP_MTHI  = 3'b100,
    MDU_OP_MTLO  = 3'b101
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } mdu_state_e;

endpackage

// File: rtl/mdu_signfix.sv
// rtl/mdu_signfix.sv - conditional two's-complement negate, used for operand abs() and result sign fix
module mdu_signfix #(
  parameter int W = 32
) (
  input  logic [W-1:0] value,
  input  logic         neg,
  output logic [W-1:0] result
);

  assign result = neg ? (~value + W'(1)) : value;

endmodule

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative radix-2 shift-add multiply / restoring divide with HI/LO registers
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int DATA_W = MDU_DATA_W,
  parameter int CNT_W  = MDU_CNT_W
) (
  input  logic              MDU_clk,
  input  logic              MDU_rst_n,
  input  logic              MDU_start,
  input  logic [2:0]        MDU_op,
  input  logic [DATA_W-1:0] MDU_rs,
  input  logic [DATA_W-1:0] MDU_rt,
  output logic              MDU_busy,
  output logic              MDU_done,
  output logic              MDU_dz,
  output logic [DATA_W-1:0] MDU_hi,
  output logic [DATA_W-1:0] MDU_lo
);

  localparam int ACC_W = 2 * DATA_W;

  mdu_state_e        state;
  logic [CNT_W-1:0]  cnt;
  logic [ACC_W-1:0]  acc;
  logic [DATA_W-1:0] a_mag;
  logic [DATA_W-1:0] b_mag;
  logic              is_div;
  logic              neg_q;
  logic              neg_r;

  logic              op_arith;
  logic              op_signed;
  logic              op_is_div;
  logic              rs_neg;
  logic              rt_neg;
  logic [DATA_W-1:0] rs_mag;
  logic [DATA_W-1:0] rt_mag;

  assign op_arith  = ~MDU_op[2];
  assign op_signed = ~MDU_op[0];
  assign op_is_div = MDU_op[1];
  assign rs_neg    = op_signed & MDU_rs[DATA_W-1];
  assign rt_neg    = op_signed & MDU_rt[DATA_W-1];

  mdu_signfix #(.W(DATA_W)) u_abs_rs (.value(MDU_rs), .neg(rs_neg), .result(rs_mag));
  mdu_signfix #(.W(DATA_W)) u_abs_rt (.value(MDU_rt), .neg(rt_neg), .result(rt_mag));

  // Multiply keeps the multiplier in the low half and shifts right; divide shifts
  // the dividend left through the remainder half, inserting quotient bits at bit 0.
  logic [DATA_W:0]   mul_sum;
  logic [DATA_W+1:0] div_diff;
  logic [ACC_W-1:0]  acc_next;

  always_comb begin
    mul_sum  = {1'b0, acc[ACC_W-1:DATA_W]} + (acc[0] ? {1'b0, a_mag} : {(DATA_W+1){1'b0}});
    div_diff = {1'b0, acc[ACC_W-1:DATA_W-1]} - {2'b00, b_mag};
    acc_next = acc;
    if (is_div) begin
      if (!div_diff[DATA_W+1]) begin
        acc_next = {div_diff[DATA_W-1:0], acc[DATA_W-2:0], 1'b1};
      end else begin
        acc_next = {acc[ACC_W-2:0], 1'b0};
      end
    end else begin
      acc_next = {mul_sum, acc[DATA_W-1:1]};
    end
  end

  logic [ACC_W-1:0]  prod_fix;
  logic [DATA_W-1:0] quo_fix;
  logic [DATA_W-1:0] rem_fix;
  logic              div_zero;

  mdu_signfix #(.W(ACC_W))  u_fix_prod (.value(acc),                    .neg(neg_q), .result(prod_fix));
  mdu_signfix #(.W(DATA_W)) u_fix_quo  (.value(acc[DATA_W-1:0]),        .neg(neg_q), .result(quo_fix));
  mdu_signfix #(.W(DATA_W)) u_fix_rem  (.value(acc[ACC_W-1:DATA_W]),    .neg(neg_r), .result(rem_fix));

  // With a zero divisor every trial subtract succeeds, so the remainder half ends
  // holding |rs|; after the dividend-sign fix that is rs itself.
  assign div_zero = is_div & (b_mag == '0);

  always_ff @(posedge MDU_clk or negedge MDU_rst_n) begin
    if (!MDU_rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      acc      <= '0;
      a_mag    <= '0;
      b_mag    <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      MDU_busy <= 1'b0;
      MDU_done <= 1'b0;
      MDU_dz   <= 1'b0;
      MDU_hi   <= '0;
      MDU_lo   <= '0;
    end else begin
      MDU_done <= 1'b0;
      MDU_dz   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (MDU_start) begin
            if (op_arith) begin
              a_mag    <= rs_mag;
              b_mag    <= rt_mag;
              is_div   <= op_is_div;
              neg_q    <= rs_neg ^ rt_neg;
              neg_r    <= rs_neg;
              acc      <= op_is_div ? {{DATA_W{1'b0}}, rs_mag} : {{DATA_W{1'b0}}, rt_mag};
              cnt      <= CNT_W'(DATA_W - 1);
              MDU_busy <= 1'b1;
              state    <= ST_RUN;
            end else if (MDU_op == MDU_OP_MTHI) begin
              MDU_hi <= MDU_rs;
            end else if (MDU_op == MDU_OP_MTLO) begin
              MDU_lo <= MDU_rs;
            end
          end
        end
        ST_RUN: begin
          acc <= acc_next;
          cnt <= cnt - CNT_W'(1);
          if (cnt == '0) begin
            state <= ST_FIX;
          end
        end
        ST_FIX: begin
          if (is_div) begin
            MDU_hi <= rem_fix;
            MDU_lo <= div_zero ? {DATA_W{1'b1}} : quo_fix;
          end else begin
            {MDU_hi, MDU_lo} <= prod_fix;
          end
          MDU_done <= 1'b1;
          MDU_dz   <= div_zero;
          MDU_busy <= 1'b0;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
